id_ex_stage: RTL and testbench

- ID/EX pipeline register that produces the registered `op_a`, `op_b` and `alu_op` consumed by the execute-stage ALU, plus the EX-stage control fields.
- Resolves RAW hazards at the ID→EX boundary: forwards from EX/MEM/WB, and stalls one cycle on load-use.
- Inserts bubbles on stall and on flush, e.g. a branch redirect.

---
 rtl/id_ex_stage.sv | 156 +++++++++++++++
 tb/tb_id_ex_stage.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves RAW hazards at the ID->EX boundary and registers ALU operands.
// Build option ID_EX_FWD_EN: when defined, forwards EX/MEM/WB results and stalls only on load-use;
// when undefined, no forwarding muxes are built and any pending producer stalls the consumer.
module id_ex_stage #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [XLEN-1:0]    id_pc,
   input  logic [RADDR_W-1:0] id_rs1_addr,
   input  logic [RADDR_W-1:0] id_rs2_addr,
   input  logic               id_rs1_used,
   input  logic               id_rs2_used,
   input  logic [XLEN-1:0]    id_rs1_data,
   input  logic [XLEN-1:0]    id_rs2_data,
   input  logic [XLEN-1:0]    id_imm,
   input  logic [3:0]         id_alu_op,
   input  logic [1:0]         id_op_a_sel,
   input  logic               id_op_b_sel,
   input  logic [RADDR_W-1:0] id_rd_addr,
   input  logic               id_rd_wren,
   input  logic               id_is_load,
   input  logic [XLEN-1:0]    ex_alu_data,
   input  logic [RADDR_W-1:0] mem_rd_addr,
   input  logic               mem_rd_wren,
   input  logic [XLEN-1:0]    mem_data,
   input  logic [RADDR_W-1:0] wb_rd_addr,
   input  logic               wb_rd_wren,
   input  logic [XLEN-1:0]    wb_data,
   input  logic               flush,
   output logic               stall,
   output logic               ex_valid,
   output logic [XLEN-1:0]    op_a,
   output logic [XLEN-1:0]    op_b,
   output logic [3:0]         alu_op,
   output logic [XLEN-1:0]    ex_pc,
   output logic [XLEN-1:0]    ex_store_data,
   output logic [RADDR_W-1:0] ex_rd_addr,
   output logic               ex_rd_wren,
   output logic               ex_is_load
);

   logic               ex_valid_q, ex_valid_d;
   logic [XLEN-1:0]    op_a_q, op_a_d;
   logic [XLEN-1:0]    op_b_q, op_b_d;
   logic [3:0]         alu_op_q, alu_op_d;
   logic [XLEN-1:0]    ex_pc_q, ex_pc_d;
   logic [XLEN-1:0]    ex_store_data_q, ex_store_data_d;
   logic [RADDR_W-1:0] ex_rd_addr_q, ex_rd_addr_d;
   logic               ex_rd_wren_q, ex_rd_wren_d;
   logic               ex_is_load_q, ex_is_load_d;

   logic rs1_ex, rs1_mem, rs1_wb, rs2_ex, rs2_mem, rs2_wb;
   logic stall_c;
   logic [XLEN-1:0] rs1_fwd, rs2_fwd;

   // x0 is hardwired zero, so a zero address never produces a hazard.
   always_comb begin
      rs1_ex  = id_rs1_used && (id_rs1_addr != '0) && ex_valid_q && ex_rd_wren_q
                && (ex_rd_addr_q == id_rs1_addr);
      rs2_ex  = id_rs2_used && (id_rs2_addr != '0) && ex_valid_q && ex_rd_wren_q
                && (ex_rd_addr_q == id_rs2_addr);
      rs1_mem = id_rs1_used && (id_rs1_addr != '0) && mem_rd_wren && (mem_rd_addr == id_rs1_addr);
      rs2_mem = id_rs2_used && (id_rs2_addr != '0) && mem_rd_wren && (mem_rd_addr == id_rs2_addr);
      rs1_wb  = id_rs1_used && (id_rs1_addr != '0) && wb_rd_wren && (wb_rd_addr == id_rs1_addr);
      rs2_wb  = id_rs2_used && (id_rs2_addr != '0) && wb_rd_wren && (wb_rd_addr == id_rs2_addr);
   end

`ifdef ID_EX_FWD_EN
   always_comb begin
      stall_c = id_valid && ex_valid_q && ex_is_load_q && (rs1_ex || rs2_ex);
      rs1_fwd = rs1_ex  ? ex_alu_data :
                rs1_mem ? mem_data    :
                rs1_wb  ? wb_data     : id_rs1_data;
      rs2_fwd = rs2_ex  ? ex_alu_data :
                rs2_mem ? mem_data    :
                rs2_wb  ? wb_data     : id_rs2_data;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{ex_alu_data, mem_data, wb_data};

   // Without forwarding the consumer waits until the producer has left WB.
   always_comb begin
      stall_c = id_valid && (rs1_ex || rs1_mem || rs1_wb || rs2_ex || rs2_mem || rs2_wb);
      rs1_fwd = id_rs1_data;
      rs2_fwd = id_rs2_data;
   end
`endif

   // Flush and stall both register a bubble; anything not captured is cleared.
   always_comb begin
      ex_valid_d      = 1'b0;
      op_a_d          = '0;
      op_b_d          = '0;
      alu_op_d        = 4'b0000;
      ex_pc_d         = '0;
      ex_store_data_d = '0;
      ex_rd_addr_d    = '0;
      ex_rd_wren_d    = 1'b0;
      ex_is_load_d    = 1'b0;
      if (!flush && !stall_c && id_valid) begin
         ex_valid_d      = 1'b1;
         case (id_op_a_sel)
            2'b00:   op_a_d = rs1_fwd;
            2'b01:   op_a_d = id_pc;
            default: op_a_d = '0;
         endcase
         op_b_d          = id_op_b_sel ? id_imm : rs2_fwd;
         alu_op_d        = id_alu_op;
         ex_pc_d         = id_pc;
         ex_store_data_d = rs2_fwd;
         ex_rd_addr_d    = id_rd_addr;
         ex_rd_wren_d    = id_rd_wren;
         ex_is_load_d    = id_is_load;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q      <= 1'b0;
         op_a_q          <= '0;
         op_b_q          <= '0;
         alu_op_q        <= 4'b0000;
         ex_pc_q         <= '0;
         ex_store_data_q <= '0;
         ex_rd_addr_q    <= '0;
         ex_rd_wren_q    <= 1'b0;
         ex_is_load_q    <= 1'b0;
      end else begin
         ex_valid_q      <= ex_valid_d;
         op_a_q          <= op_a_d;
         op_b_q          <= op_b_d;
         alu_op_q        <= alu_op_d;
         ex_pc_q         <= ex_pc_d;
         ex_store_data_q <= ex_store_data_d;
         ex_rd_addr_q    <= ex_rd_addr_d;
         ex_rd_wren_q    <= ex_rd_wren_d;
         ex_is_load_q    <= ex_is_load_d;
      end
   end

   assign stall         = stall_c;
   assign ex_valid      = ex_valid_q;
   assign op_a          = op_a_q;
   assign op_b          = op_b_q;
   assign alu_op        = alu_op_q;
   assign ex_pc         = ex_pc_q;
   assign ex_store_data = ex_store_data_q;
   assign ex_rd_addr    = ex_rd_addr_q;
   assign ex_rd_wren    = ex_rd_wren_q;
   assign ex_is_load    = ex_is_load_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; exercises the forwarding or the stall-only build per ID_EX_FWD_EN.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [3:0]  alu_op;
      logic [31:0] pc;
      logic [31:0] store;
      logic [4:0]  rd;
      logic        wren;
      logic        load;
   } ex_t;

   typedef struct packed {
      ex_t v;
      ex_t m;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [4:0]  id_rs1_addr, id_rs2_addr;
   logic        id_rs1_used, id_rs2_used;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic [3:0]  id_alu_op;
   logic [1:0]  id_op_a_sel;
   logic        id_op_b_sel;
   logic [4:0]  id_rd_addr;
   logic        id_rd_wren, id_is_load;
   logic [31:0] ex_alu_data;
   logic [4:0]  mem_rd_addr;
   logic        mem_rd_wren;
   logic [31:0] mem_data;
   logic [4:0]  wb_rd_addr;
   logic        wb_rd_wren;
   logic [31:0] wb_data;
   logic        flush;
   logic        stall, ex_valid, ex_rd_wren, ex_is_load;
   logic [31:0] op_a, op_b, ex_pc, ex_store_data;
   logic [3:0]  alu_op;
   logic [4:0]  ex_rd_addr;

   ex_t got;
   sb_t exp_q[$];
   sb_t s;
   int  checks   = 0;
   int  failures = 0;

   id_ex_stage #(.XLEN(32), .RADDR_W(5)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_alu_op(id_alu_op), .id_op_a_sel(id_op_a_sel), .id_op_b_sel(id_op_b_sel),
      .id_rd_addr(id_rd_addr), .id_rd_wren(id_rd_wren), .id_is_load(id_is_load),
      .ex_alu_data(ex_alu_data), .mem_rd_addr(mem_rd_addr), .mem_rd_wren(mem_rd_wren),
      .mem_data(mem_data), .wb_rd_addr(wb_rd_addr), .wb_rd_wren(wb_rd_wren), .wb_data(wb_data),
      .flush(flush), .stall(stall), .ex_valid(ex_valid), .op_a(op_a), .op_b(op_b),
      .alu_op(alu_op), .ex_pc(ex_pc), .ex_store_data(ex_store_data),
      .ex_rd_addr(ex_rd_addr), .ex_rd_wren(ex_rd_wren), .ex_is_load(ex_is_load)
   );

   always #5 clk = ~clk;

   assign got = {ex_valid, op_a, op_b, alu_op, ex_pc, ex_store_data, ex_rd_addr, ex_rd_wren, ex_is_load};

   function automatic ex_t full_mask();
      ex_t m = '1;
      return m;
   endfunction

   // A bubble only defines the control bits and the ALU inputs.
   function automatic ex_t bub_mask();
      ex_t m = '0;
      m.valid = 1'b1; m.op_a = '1; m.op_b = '1; m.alu_op = '1; m.wren = 1'b1; m.load = 1'b1;
      return m;
   endfunction

   function automatic ex_t cap(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] aop, input logic [31:0] st, input logic [4:0] rd,
                               input logic wr, input logic ld);
      ex_t e;
      e.valid = 1'b1; e.op_a = a; e.op_b = b; e.alu_op = aop; e.pc = pc;
      e.store = st; e.rd = rd; e.wren = wr; e.load = ld;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
      id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_op = 0; id_op_a_sel = 0; id_op_b_sel = 0;
      id_rd_addr = 0; id_rd_wren = 0; id_is_load = 0; ex_alu_data = 0; mem_rd_addr = 0;
      mem_rd_wren = 0; mem_data = 0; wb_rd_addr = 0; wb_rd_wren = 0; wb_data = 0; flush = 0;
   endtask

   task automatic set_id(input logic [31:0] pc, input logic [4:0] r1, input logic u1,
                         input logic [31:0] d1, input logic [4:0] r2, input logic u2,
                         input logic [31:0] d2, input logic [31:0] imm, input logic [3:0] aop,
                         input logic [1:0] asel, input logic bsel, input logic [4:0] rd,
                         input logic wr, input logic ld);
      id_valid = 1; id_pc = pc; id_rs1_addr = r1; id_rs1_used = u1; id_rs1_data = d1;
      id_rs2_addr = r2; id_rs2_used = u2; id_rs2_data = d2; id_imm = imm; id_alu_op = aop;
      id_op_a_sel = asel; id_op_b_sel = bsel; id_rd_addr = rd; id_rd_wren = wr; id_is_load = ld;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      id_valid = 1'($urandom); id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
      id_imm = $urandom; id_alu_op = 4'($urandom); id_rd_addr = 5'($urandom); id_rd_wren = 1;
      id_is_load = 1'($urandom); id_op_a_sel = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (got !== '0) begin
            failures++;
            $display("FAIL reset_outputs cycle=%0d got=%h exp=0", i, got);
         end
      end
      idle();
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL reset_stall got=%b exp=0", stall);
      end
      rst = 0;
   endtask

   task automatic test_capture();
      logic [31:0] pc, d1, d2, imm, a, b;
      for (int i = 0; i < 4; i++) begin
         idle();
         pc = 32'h100 + 32'(i * 4); d1 = 32'h1111_0000 + 32'(i); d2 = 32'h2222_0000 + 32'(i);
         imm = 32'h0000_0F00 + 32'(i);
         set_id(pc, 5'd1, 1, d1, 5'd2, 1, d2, imm, 4'(i + 2), 2'(i), 1'(i % 2), 5'(10 + i), 1, 0);
         a = (i == 0) ? d1 : (i == 1) ? pc : 32'h0;
         b = (i % 2 == 1) ? imm : d2;
         #1;
         checks++;
         if (stall !== 1'b0) begin
            failures++;
            $display("FAIL capture_stall pattern=%0d got=%b exp=0", i, stall);
         end
         exp_q.push_back('{cap(pc, a, b, 4'(i + 2), d2, 5'(10 + i), 1, 0), full_mask()});
         tick();
         s = exp_q.pop_front();
         checks++;
         if (((got ^ s.v) & s.m) !== '0) begin
            failures++;
            $display("FAIL capture pattern=%0d got=%h exp=%h", i, got, s.v);
         end
      end
   endtask

   task automatic test_x0();
      idle();
      set_id(32'h200, 5'd0, 0, 0, 5'd0, 0, 0, 32'h5, 4'h0, 2'b00, 1, 5'd0, 1, 0);
      exp_q.push_back('{cap(32'h200, 0, 32'h5, 4'h0, 0, 5'd0, 1, 0), full_mask()});
      tick();
      s = exp_q.pop_front();
      checks++;
      if (((got ^ s.v) & s.m) !== '0) begin
         failures++;
         $display("FAIL x0_producer got=%h exp=%h", got, s.v);
      end
      idle();
      set_id(32'h204, 5'd0, 1, 0, 5'd0, 1, 0, 0, 4'h0, 2'b00, 0, 5'd4, 1, 0);
      ex_alu_data = 32'h0000_FFFF;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL x0_stall got=%b exp=0", stall);
      end
      exp_q.push_back('{cap(32'h204, 0, 0, 4'h0, 0, 5'd4, 1, 0), full_mask()});
      tick();
      s = exp_q.pop_front();
      checks++;
      if (((got ^ s.v) & s.m) !== '0) begin
         failures++;
         $display("FAIL x0_no_forward got=%h exp=%h", got, s.v);
      end
   endtask

   task automatic test_flush();
      idle();
      set_id(32'h300, 5'd1, 1, 32'h9, 5'd2, 1, 32'h8, 0, 4'h3, 2'b00, 0, 5'd14, 1, 1);
      flush = 1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL flush_stall got=%b exp=0", stall);
      end
      exp_q.push_back('{ex_t'('0), bub_mask()});
      tick();
      s = exp_q.pop_front();
      checks++;
      if (((got ^ s.v) & s.m) !== '0) begin
         failures++;
         $display("FAIL flush_bubble got=%h exp=%h", got, s.v);
      end
   endtask

`ifdef ID_EX_FWD_EN
   task automatic test_ex_forward();
      idle();
      set_id(32'h400, 5'd1, 1, 32'h8, 5'd2, 1, 32'h8, 0, 4'h0, 2'b00, 0, 5'd5, 1, 0);
      exp_q.push_back('{cap(32'h400, 32'h8, 32'h8, 4'h0, 32'h8, 5'd5, 1, 0), full_mask()});
      tick();
      s = exp_q.pop_front();
      checks++;
      if (((got ^ s.v) & s.m) !== '0) begin
         failures++;
         $display("FAIL ex_fwd_producer got=%h exp=%h", got, s.v);
      end
      idle();
      set_id(32'h404, 5'd5, 1, 32'h0, 5'd6, 1, 32'h3, 0, 4'b0001, 2'b00, 0, 5'd0, 0, 0);
      ex_alu_data = 32'h0000_0010;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL ex_fwd_stall got=%b exp=0", stall);
      end
      exp_q.push_back('{cap(32'h404, 32'h10, 32'h3, 4'b0001, 32'h3, 5'd0, 0, 0), full_mask()});
      tick();
      s = exp_q.pop_front();
      checks++;
      if (((got ^ s.v) & s.m) !== '0) begin
         failures++;
         $display("FAIL ex_forward got=%h exp=%h", got, s.v);
      end
   endtask

   task automatic test_priority();
      logic [31:0] want;
      for (int i = 0; i < 2; i++) begin
         idle();
         set_id(32'h500, 5'd7, 1, 32'h1, 5'd7, 1, 32'h1, 0, 4'h0, 2'b00, 0, 5'd0, 0, 0);
         mem_rd_addr = 5'd7; mem_rd_wren = (i == 0); mem_data = 32'hAAAA_0000;
         wb_rd_addr = 5'd7; wb_rd_wren = 1; wb_data = 32'h0000_5555;
         want = (i == 0) ? 32'hAAAA_0000 : 32'h0000_5555;
         exp_q.push_back('{cap(32'h500, want, want, 4'h0, want, 5'd0, 0, 0), full_mask()});
         tick();
         s = exp_q.pop_front();
         checks++;
         if (((got ^ s.v) & s.m) !== '0) begin
            failures++;
            $display("FAIL priority case=%0d got=%h exp=%h", i, got, s.v);
         end
      end
   endtask

   task automatic test_load_use();
      for (int k = 0; k < 2; k++) begin
         idle();
         set_id(32'h600, 5'd1, 1, 32'h40, 5'd0, 0, 0, 32'h4, 4'h0, 2'b00, 1, 5'd8, 1, 1);
         exp_q.push_back('{cap(32'h600, 32'h40, 32'h4, 4'h0, 0, 5'd8, 1, 1), full_mask()});
         tick();
         s = exp_q.pop_front();
         checks++;
         if (((got ^ s.v) & s.m) !== '0) begin
            failures++;
            $display("FAIL load_producer pass=%0d got=%h exp=%h", k, got, s.v);
         end
         idle();
         set_id(32'h604, 5'd8, 1, 32'h0, 5'd0, 0, 0, 32'h1, 4'h0, 2'b00, 1, 5'd9, 1, 0);
         flush = (k == 1);
         #1;
         checks++;
         if (stall !== 1'b1) begin
            failures++;
            $display("FAIL load_use_stall pass=%0d got=%b exp=1", k, stall);
         end
         exp_q.push_back('{ex_t'('0), bub_mask()});
         tick();
         s = exp_q.pop_front();
         checks++;
         if (((got ^ s.v) & s.m) !== '0) begin
            failures++;
            $display("FAIL load_use_bubble pass=%0d got=%h exp=%h", k, got, s.v);
         end
      end
      flush = 0;
      mem_rd_addr = 5'd8; mem_rd_wren = 1; mem_data = 32'h0000_1234;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL load_use_release got=%b exp=0", stall);
      end
      exp_q.push_back('{cap(32'h604, 32'h1234, 32'h1, 4'h0, 0, 5'd9, 1, 0), full_mask()});
      tick();
      s = exp_q.pop_front();
      checks++;
      if (((got ^ s.v) & s.m) !== '0) begin
         failures++;
         $display("FAIL load_use_forward got=%h exp=%h", got, s.v);
      end
   endtask
`else
   // Consumer of x3 waits while the producer sits in MEM, then WB, then issues.
   task automatic test_mem_stall();
      logic exp_stall;
      for (int c = 0; c < 3; c++) begin
         idle();
         set_id(32'h700, 5'd3, 1, 32'hCAFE_0003, 5'd0, 0, 32'h5, 0, 4'h0, 2'b00, 0, 5'd11, 1, 0);
         mem_rd_addr = 5'd3; mem_rd_wren = (c == 0); mem_data = 32'h999;
         wb_rd_addr = 5'd3; wb_rd_wren = (c == 1); wb_data = 32'h888;
         flush = (c == 0);
         exp_stall = (c < 2);
         #1;
         checks++;
         if (stall !== exp_stall) begin
            failures++;
            $display("FAIL mem_stall cycle=%0d got=%b exp=%b", c, stall, exp_stall);
         end
         if (c < 2) exp_q.push_back('{ex_t'('0), bub_mask()});
         else exp_q.push_back('{cap(32'h700, 32'hCAFE_0003, 32'h5, 4'h0, 32'h5, 5'd11, 1, 0), full_mask()});
         tick();
         s = exp_q.pop_front();
         checks++;
         if (((got ^ s.v) & s.m) !== '0) begin
            failures++;
            $display("FAIL mem_stall_out cycle=%0d got=%h exp=%h", c, got, s.v);
         end
      end
   endtask

   task automatic test_ex_stall();
      idle();
      set_id(32'h800, 5'd0, 0, 0, 5'd0, 0, 0, 32'h7, 4'h0, 2'b10, 1, 5'd9, 1, 0);
      exp_q.push_back('{cap(32'h800, 0, 32'h7, 4'h0, 0, 5'd9, 1, 0), full_mask()});
      tick();
      s = exp_q.pop_front();
      checks++;
      if (((got ^ s.v) & s.m) !== '0) begin
         failures++;
         $display("FAIL ex_stall_producer got=%h exp=%h", got, s.v);
      end
      for (int c = 0; c < 2; c++) begin
         idle();
         set_id(32'h804, 5'd0, 0, 0, 5'd9, 1, 32'h42, 0, 4'h2, 2'b10, 0, 5'd10, 1, 0);
         #1;
         checks++;
         if (stall !== (c == 0)) begin
            failures++;
            $display("FAIL ex_stall cycle=%0d got=%b exp=%b", c, stall, (c == 0));
         end
         if (c == 0) exp_q.push_back('{ex_t'('0), bub_mask()});
         else exp_q.push_back('{cap(32'h804, 0, 32'h42, 4'h2, 32'h42, 5'd10, 1, 0), full_mask()});
         tick();
         s = exp_q.pop_front();
         checks++;
         if (((got ^ s.v) & s.m) !== '0) begin
            failures++;
            $display("FAIL ex_stall_out cycle=%0d got=%h exp=%h", c, got, s.v);
         end
      end
   endtask
`endif

   task automatic test_invalid();
      idle();
      set_id(32'h900, 5'd0, 0, 0, 5'd0, 0, 0, 0, 4'h0, 2'b00, 0, 5'd12, 1, 1);
      exp_q.push_back('{cap(32'h900, 0, 0, 4'h0, 0, 5'd12, 1, 1), full_mask()});
      tick();
      s = exp_q.pop_front();
      checks++;
      if (((got ^ s.v) & s.m) !== '0) begin
         failures++;
         $display("FAIL invalid_producer got=%h exp=%h", got, s.v);
      end
      idle();
      set_id(32'h904, 5'd12, 1, 32'h3, 5'd12, 1, 32'h3, 0, 4'h5, 2'b00, 0, 5'd1, 1, 0);
      id_valid = 0;
      mem_rd_addr = 5'd12; mem_rd_wren = 1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL invalid_stall got=%b exp=0", stall);
      end
      exp_q.push_back('{ex_t'('0), bub_mask()});
      tick();
      s = exp_q.pop_front();
      checks++;
      if (((got ^ s.v) & s.m) !== '0) begin
         failures++;
         $display("FAIL invalid_bubble got=%h exp=%h", got, s.v);
      end
   endtask

   task automatic test_reset_mid_stall();
      idle();
      set_id(32'hA00, 5'd0, 0, 0, 5'd0, 0, 0, 0, 4'h0, 2'b10, 1, 5'd13, 1, 1);
      exp_q.push_back('{cap(32'hA00, 0, 0, 4'h0, 0, 5'd13, 1, 1), full_mask()});
      tick();
      s = exp_q.pop_front();
      checks++;
      if (((got ^ s.v) & s.m) !== '0) begin
         failures++;
         $display("FAIL rms_producer got=%h exp=%h", got, s.v);
      end
      idle();
      set_id(32'hA04, 5'd13, 1, 32'h77, 5'd0, 0, 32'h6, 0, 4'h4, 2'b00, 0, 5'd2, 1, 0);
      #1;
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("FAIL rms_stall_before got=%b exp=1", stall);
      end
      rst = 1;
      exp_q.push_back('{ex_t'('0), full_mask()});
      tick();
      rst = 0;
      s = exp_q.pop_front();
      checks++;
      if (((got ^ s.v) & s.m) !== '0) begin
         failures++;
         $display("FAIL rms_reset got=%h exp=%h", got, s.v);
      end
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL rms_stall_after got=%b exp=0", stall);
      end
      exp_q.push_back('{cap(32'hA04, 32'h77, 32'h6, 4'h4, 32'h6, 5'd2, 1, 0), full_mask()});
      tick();
      s = exp_q.pop_front();
      checks++;
      if (((got ^ s.v) & s.m) !== '0) begin
         failures++;
         $display("FAIL rms_capture got=%h exp=%h", got, s.v);
      end
   endtask

   initial begin
      idle();
      rst = 1;
      test_reset();
      test_capture();
      test_x0();
      test_flush();
`ifdef ID_EX_FWD_EN
      test_ex_forward();
      test_priority();
      test_load_use();
`else
      test_mem_stall();
      test_ex_stall();
`endif
      test_invalid();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached without finishing");
      $fatal(1);
   end

endmodule
